// File: rtl/mmio_uart_bridge.sv
// MMIO slave bridging CPU loads/stores to UART RX/TX FIFOs plus cycle/instret counters.
// Load data is registered (1 cycle); UART sides use valid/ready, full TX drops writes and flags overflow.

module mmio_uart_bridge_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // Gating uses pre-cycle state: a pop never frees room for a same-cycle push, nor vice versa.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module mmio_uart_bridge #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [31:0] io_rdata,
    input  logic        inst_retired,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [28:0] rsvd;
        logic        tx_overflow;
        logic        rx_nonempty;
        logic        tx_notfull;
    } status_t;

    logic        sel;
    logic [7:0]  off;
    logic        rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]  rx_head, tx_head;
    logic        rx_pop, tx_push, tx_pop, clr;
    logic        tx_overflow;
    logic [31:0] cycle_cnt, inst_cnt;
    logic [31:0] rdata_nxt;
    status_t     status;
    logic        unused_bits;

    assign sel         = (io_addr[31:28] == 4'h8);
    assign off         = io_addr[7:0];
    assign rx_pop      = io_re && sel && (off == 8'h04);
    assign tx_push     = io_we && sel && (off == 8'h08);
    assign clr         = io_we && sel && (off == 8'h18);
    assign tx_pop      = uart_tx_valid && uart_tx_ready;
    assign unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

    assign uart_rx_ready = !rx_full;
    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_head;

    mmio_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W), .W(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (uart_rx_valid && uart_rx_ready),
        .pop   (rx_pop),
        .wdata (uart_rx_data),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    mmio_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W), .W(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (io_wdata[7:0]),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_comb begin
        status             = '0;
        status.tx_overflow = tx_overflow;
        status.rx_nonempty = !rx_empty;
        status.tx_notfull  = !tx_full;
        rdata_nxt          = '0;
        if (sel) begin
            case (off)
                8'h00:   rdata_nxt = status;
                8'h04:   rdata_nxt = rx_empty ? 32'h0 : {24'h0, rx_head};
                8'h10:   rdata_nxt = cycle_cnt;
                8'h14:   rdata_nxt = inst_cnt;
                default: rdata_nxt = '0;
            endcase
        end
    end

    // Clear beats the same-cycle increment so software sees a clean zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_rdata    <= '0;
            cycle_cnt   <= '0;
            inst_cnt    <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (io_re) io_rdata <= rdata_nxt;
            if (clr) begin
                cycle_cnt   <= '0;
                inst_cnt    <= '0;
                tx_overflow <= 1'b0;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
                if (inst_retired) inst_cnt <= inst_cnt + 32'd1;
                if (tx_push && tx_full) tx_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Randomized + directed bench for mmio_uart_bridge against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared at the same point.

module tb_mmio_uart_bridge;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_we;
    logic        io_re;
    logic [31:0] io_rdata;
    logic        inst_retired;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    mmio_uart_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_we         (io_we),
        .io_re         (io_re),
        .io_rdata      (io_rdata),
        .inst_retired  (inst_retired),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic        m_ovf;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    logic [31:0] m_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: update the model from the applied inputs, then compare outputs.
    task automatic step();
        int          rx_n;
        int          tx_n;
        bit          in_io;
        logic [7:0]  off;
        logic [31:0] rd_val;
        logic [7:0]  dummy;
        if (!rst_n) begin
            rx_q.delete();
            tx_q.delete();
            m_ovf   = 1'b0;
            m_cyc   = '0;
            m_inst  = '0;
            m_rdata = '0;
        end else begin
            rx_n  = rx_q.size();
            tx_n  = tx_q.size();
            in_io = (io_addr[31:28] == 4'h8);
            off   = io_addr[7:0];
            if (io_re) begin
                rd_val = '0;
                if (in_io) begin
                    if (off == 8'h00) rd_val = {29'b0, m_ovf, rx_n != 0, tx_n < DEPTH};
                    if (off == 8'h04 && rx_n != 0) rd_val = {24'b0, rx_q[0]};
                    if (off == 8'h10) rd_val = m_cyc;
                    if (off == 8'h14) rd_val = m_inst;
                end
                m_rdata = rd_val;
                if (in_io && off == 8'h04 && rx_n != 0) dummy = rx_q.pop_front();
            end
            if (tx_n != 0 && uart_tx_ready) dummy = tx_q.pop_front();
            if (uart_rx_valid && rx_n < DEPTH) rx_q.push_back(uart_rx_data);
            if (io_we && in_io && off == 8'h08) begin
                if (tx_n < DEPTH) tx_q.push_back(io_wdata[7:0]);
                else m_ovf = 1'b1;
            end
            if (io_we && in_io && off == 8'h18) begin
                m_cyc  = '0;
                m_inst = '0;
                m_ovf  = 1'b0;
            end else begin
                m_cyc = m_cyc + 32'd1;
                if (inst_retired) m_inst = m_inst + 32'd1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("io_rdata", io_rdata, m_rdata);
        check_eq("rx_ready", {31'b0, uart_rx_ready}, {31'b0, rx_q.size() < DEPTH});
        check_eq("tx_valid", {31'b0, uart_tx_valid}, {31'b0, tx_q.size() != 0});
        if (tx_q.size() != 0) check_eq("tx_data", {24'b0, uart_tx_data}, {24'b0, tx_q[0]});
    endtask

    task automatic rd(input logic [31:0] a);
        io_addr = a;
        io_re   = 1'b1;
        step();
        io_re   = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io_addr  = a;
        io_wdata = d;
        io_we    = 1'b1;
        step();
        io_we    = 1'b0;
    endtask

    logic [31:0] addr_tbl [8];
    logic [31:0] got1;
    logic [31:0] got2;

    initial begin
        addr_tbl[0] = 32'h8000_0000; addr_tbl[1] = 32'h8000_0004;
        addr_tbl[2] = 32'h8000_0008; addr_tbl[3] = 32'h8000_0010;
        addr_tbl[4] = 32'h8000_0014; addr_tbl[5] = 32'h8000_0018;
        addr_tbl[6] = 32'h8000_000C; addr_tbl[7] = 32'h4000_0004;

        rst_n = 1'b0; io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
        inst_retired = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;

        // Reset
        step(); step();
        rst_n = 1'b1;
        check_eq("rst_tx_data", {24'b0, uart_tx_data}, 32'h0);
        check_eq("rst_rdata", io_rdata, 32'h0);
        rd(32'h8000_0000);
        check_eq("rst_status", io_rdata, 32'h1);

        // TX fill and overflow, then drain
        for (int i = 0; i < 9; i++) wr(32'h8000_0008, 32'h41 + i);
        rd(32'h8000_0000);
        check_eq("tx_full_status", io_rdata, 32'h4);
        check_eq("tx_head_first", {24'b0, uart_tx_data}, 32'h41);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check_eq("tx_drained", {31'b0, uart_tx_valid}, 32'h0);
        uart_tx_ready = 1'b0;
        wr(32'h8000_0018, 32'h0);

        // RX path
        uart_rx_valid = 1'b1; uart_rx_data = 8'h55; step();
        uart_rx_data = 8'hAA; step();
        uart_rx_valid = 1'b0;
        rd(32'h8000_0000); check_eq("rx_status", io_rdata, 32'h3);
        rd(32'h8000_0004); check_eq("rx_byte0", io_rdata, 32'h55);
        rd(32'h8000_0004); check_eq("rx_byte1", io_rdata, 32'hAA);
        rd(32'h8000_0004); check_eq("rx_empty_rd", io_rdata, 32'h0);

        // RX full and release by one read
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            uart_rx_data = 8'(8'h10 + i);
            step();
        end
        check_eq("rx_full_ready", {31'b0, uart_rx_ready}, 32'h0);
        rd(32'h8000_0004);
        check_eq("rx_full_pop", io_rdata, 32'h10);
        check_eq("rx_ready_back", {31'b0, uart_rx_ready}, 32'h1);
        uart_rx_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) rd(32'h8000_0004);

        // Counters
        wr(32'h8000_0018, 32'hDEAD_BEEF);
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i % 2 == 1);
            step();
        end
        inst_retired = 1'b0;
        rd(32'h8000_0014); check_eq("inst_cnt50", io_rdata, 32'd50);
        rd(32'h8000_0010); check_eq("cycle_cnt", io_rdata, 32'd101);
        wr(32'h8000_0018, 32'h0);
        rd(32'h8000_0010); check_eq("cnt_cleared", io_rdata, 32'h0);

        // Reset in the middle of a transmission
        for (int i = 0; i < 3; i++) wr(32'h8000_0008, 32'hC0 + i);
        uart_tx_ready = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("rst_mid_txv", {31'b0, uart_tx_valid}, 32'h0);
        rd(32'h8000_0000); check_eq("rst_mid_status", io_rdata, 32'h1);
        uart_tx_ready = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] op;
            op            = 3'($urandom_range(0, 7));
            uart_rx_valid = ($urandom_range(0, 1) == 1);
            uart_rx_data  = 8'($urandom);
            uart_tx_ready = ($urandom_range(0, 2) != 0);
            inst_retired  = ($urandom_range(0, 1) == 1);
            io_addr       = addr_tbl[$urandom_range(0, 7)];
            if (io_addr[7:0] == 8'h18 && $urandom_range(0, 3) != 0) io_addr = 32'h8000_0008;
            io_wdata      = $urandom;
            io_re         = op[0];
            io_we         = op[1];
            rst_n         = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1; io_re = 1'b0; io_we = 1'b0; uart_rx_valid = 1'b0; inst_retired = 1'b0;
        step();

        // Cycle counter wrap
        @(negedge clk);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cycle_cnt;
        io_addr = 32'h8000_0010;
        io_re   = 1'b1;
        @(negedge clk);
        got1 = io_rdata;
        @(negedge clk);
        got2 = io_rdata;
        io_re = 1'b0;
        check_eq("cnt_wrap", {31'b0, got2 < 32'd4}, 32'h1);
        check_eq("cnt_wrap_prog", {31'b0, got1 == 32'hFFFF_FFFF || got1 < 32'd4}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_uart_bridge.md
Name: mmio_uart_bridge

Overview:
Memory-mapped I/O slave between the CPU memory/writeback stage and the on-chip `uart`. It buffers RX and TX bytes in FIFOs, so software polling is decoupled from serial timing. It also holds the cycle and retired-instruction counters. It decodes the 0x8000_00xx region and returns registered read data one cycle after a request, matching the latency of the BIOS and DMEM reads.

Parameters:
FIFO_DEPTH, 8, entries per FIFO; power of two, minimum 2
PTR_W, $clog2(FIFO_DEPTH), pointer width (derived)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
io_addr  input  32  byte address from the execute-stage ALU result
io_wdata  input  32  store data; bits [7:0] used for TX
io_we  input  1  store strobe (any byte-mask bit set)
io_re  input  1  load strobe
io_rdata  output  32  registered load data, valid the cycle after io_re
inst_retired  input  1  pulse per retired non-bubble instruction
uart_rx_data  input  8  byte from UART receiver
uart_rx_valid  input  1  receiver byte valid
uart_rx_ready  output  1  bridge accepts RX byte
uart_tx_data  output  8  byte to UART transmitter
uart_tx_valid  output  1  TX byte available
uart_tx_ready  input  1  transmitter accepts byte

Behaviour:
- Decode is active only when io_addr[31:28]==4'h8. Offsets use io_addr[7:0]. Other addresses are ignored, and io_rdata returns 0 on the next cycle.
- Address map:
  - 0x00 R: {29'b0, tx_overflow, rx_nonempty, tx_notfull}
  - 0x04 R: RX byte {24'b0, head}; pops the RX FIFO
  - 0x08 W: push io_wdata[7:0] to the TX FIFO
  - 0x10 R: cycle_cnt
  - 0x14 R: inst_cnt
  - 0x18 W (any data): clears both counters and tx_overflow
- Reset (rst_n low at a posedge):
  - Both FIFOs empty; pointers and counts = 0.
  - cycle_cnt = inst_cnt = 0; tx_overflow = 0; io_rdata = 0.
  - uart_rx_ready = 1, uart_tx_valid = 0, uart_tx_data = 0.
- Reset asserted mid-transfer discards all FIFO contents. No partial byte is retained.
- io_rdata is registered: the value for a load at cycle N appears at N+1 and holds until the next load. A non-load cycle does not change io_rdata.
- RX FIFO:
  - uart_rx_ready = !rx_full.
  - Push when uart_rx_valid && uart_rx_ready.
  - A CPU read of 0x04 pops only if rx_nonempty. On empty it returns 0x0000_0000 and does not move the pointer.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When empty, a same-cycle push is not visible to a same-cycle pop. The read returns 0 and the count becomes 1.
- TX FIFO:
  - uart_tx_valid = !tx_empty; uart_tx_data = head entry (combinational from storage).
  - Pop when uart_tx_valid && uart_tx_ready.
  - A write to 0x08 pushes if not full. If full, the byte is dropped and tx_overflow sets (sticky until a 0x18 write or reset).
  - When full, a same-cycle pop does not enable a push; the write is still dropped.
  - Simultaneous push and pop when not full or empty: count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty uses a PTR_W+1 bit count register.
- Status bit 0x00 reflects state before the current cycle's updates.
- Counters:
  - 32-bit; cycle_cnt increments every cycle out of reset.
  - inst_cnt increments when inst_retired = 1.
  - Both wrap from 0xFFFF_FFFF to 0.
  - A 0x18 write takes priority over the same-cycle increment: the counter value is 0 the following cycle.
- Simultaneous io_re and io_we: both act. A read returns pre-write state.
- Accesses to unmapped offsets in 0x8 space: reads return 0, writes have no effect.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> io_rdata=0, uart_tx_valid=0, uart_rx_ready=1; read 0x00 -> 0x0000_0001.
- TX fill: write 0x41..0x49 (9 bytes) to 0x08 with uart_tx_ready=0 -> 8 accepted, 0x49 dropped, read 0x00 -> 0x4. Then raise uart_tx_ready -> bytes 0x41..0x48 emitted in order, 1 per cycle, then uart_tx_valid=0.
- RX path: drive 0x55 then 0xAA on uart_rx_valid -> 0x00 reads 0x3. Reads of 0x04 return 0x55, 0xAA, then 0x0 (empty, no pop).
- RX full: push 8 bytes with no reads -> uart_rx_ready=0 and the 9th byte is held off. One 0x04 read -> uart_rx_ready=1 on the next cycle.
- Counters: run 100 cycles with inst_retired toggling every other cycle -> 0x10 ≈ 100, 0x14 = 50. Write 0x18 -> next reads count from 0. Force cycle_cnt=0xFFFF_FFFF -> wraps to 0.
- Reset mid-operation: TX FIFO holding 3 bytes with transmission in progress, drop rst_n for 1 cycle -> uart_tx_valid=0, 0x00 reads 0x1, no stale byte emitted.
